// File: rtl/inst_fetch.sv
// Instruction fetch stage: drives the ROM from the PC and buffers up to two
// fetched {pc, inst} pairs for decode, with one-cycle redirect on branch.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        rom_ce,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_inst,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst
);

    logic [31:0] pc;
    logic [31:0] buf_pc   [2];
    logic [31:0] buf_inst [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;
    logic        pop;
    logic        fetch;

    assign pop   = if_valid && if_ready;
    // A pop frees a slot in the same cycle, so a full buffer still fetches.
    assign fetch = rst && !branch_flag && ((count != 2'd2) || pop);

    assign rom_ce   = fetch;
    assign rom_addr = pc;

    assign if_valid = (count != 2'd0);
    assign if_pc    = if_valid ? buf_pc[rd_ptr]   : 32'h0;
    assign if_inst  = if_valid ? buf_inst[rd_ptr] : 32'h0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc     <= RESET_PC;
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else if (branch_flag) begin
            // Redirect flushes everything, including an entry decode took this cycle.
            pc     <= {branch_target[31:2], 2'b00};
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (fetch) begin
                pc     <= pc + 32'd4;
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({fetch, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible while count covers them.
    always_ff @(posedge clk) begin
        if (fetch) begin
            buf_pc[wr_ptr]   <= pc;
            buf_inst[wr_ptr] <= rom_inst;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: per-cycle scoreboard model plus vector table and
// hand sequences for reset, backpressure, branch, wrap and mid-run reset.
module tb_inst_fetch;

    logic        clk;
    logic        rst;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_inst;

    logic        rst_w;
    logic        rom_ce_w;
    logic [31:0] rom_addr_w;
    logic [31:0] rom_inst_w;
    logic        if_valid_w;
    logic [31:0] if_pc_w;
    logic [31:0] if_inst_w;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    typedef struct {
        logic        ready;
        logic        br;
        logic [31:0] tgt;
        logic        ce;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
    } vec_t;

    ent_t        q[$];
    logic [31:0] exp_pc = 32'h0;
    vec_t        tbl[13];

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return 32'h1000_0000 + (a >> 2);
    endfunction

    assign rom_inst   = rom_word(rom_addr);
    assign rom_inst_w = rom_word(rom_addr_w);

    inst_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .rom_ce        (rom_ce),
        .rom_addr      (rom_addr),
        .rom_inst      (rom_inst),
        .branch_flag   (branch_flag),
        .branch_target (branch_target),
        .if_valid      (if_valid),
        .if_ready      (if_ready),
        .if_pc         (if_pc),
        .if_inst       (if_inst)
    );

    inst_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
        .clk           (clk),
        .rst           (rst_w),
        .rom_ce        (rom_ce_w),
        .rom_addr      (rom_addr_w),
        .rom_inst      (rom_inst_w),
        .branch_flag   (1'b0),
        .branch_target (32'h0),
        .if_valid      (if_valid_w),
        .if_ready      (1'b1),
        .if_pc         (if_pc_w),
        .if_inst       (if_inst_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: tracks PC and buffered entries independently of the DUT.
    always @(negedge clk) begin
        logic exp_pop;
        logic exp_fetch;
        ent_t e;
        if (!rst) begin
            chk("rst_ce", {31'h0, rom_ce}, 32'h0);
            chk("rst_addr", rom_addr, 32'h0);
            chk("rst_valid", {31'h0, if_valid}, 32'h0);
            chk("rst_pc", if_pc, 32'h0);
            chk("rst_inst", if_inst, 32'h0);
            q.delete();
            exp_pc = 32'h0;
        end else begin
            exp_pop   = (q.size() != 0) && if_ready;
            exp_fetch = !branch_flag && ((q.size() < 2) || exp_pop);
            chk("sb_valid", {31'h0, if_valid}, {31'h0, (q.size() != 0)});
            chk("sb_ce", {31'h0, rom_ce}, {31'h0, exp_fetch});
            chk("sb_addr", rom_addr, exp_pc);
            if (q.size() != 0) begin
                chk("sb_head_pc", if_pc, q[0].pc);
                chk("sb_head_inst", if_inst, q[0].inst);
            end else begin
                chk("sb_empty_pc", if_pc, 32'h0);
                chk("sb_empty_inst", if_inst, 32'h0);
            end
            if (exp_pop) begin
                e = q.pop_front();
            end
            if (branch_flag) begin
                q.delete();
                exp_pc = {branch_target[31:2], 2'b00};
            end else if (exp_fetch) begin
                q.push_back({exp_pc, rom_word(exp_pc)});
                exp_pc = exp_pc + 32'd4;
            end
        end
    end

    initial begin
        // ready, br, tgt, ce, addr, valid, pc
        tbl[0]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h000, 1'b0, 32'h000};
        tbl[1]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h004, 1'b1, 32'h000};
        tbl[2]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h008, 1'b1, 32'h000};
        tbl[3]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h008, 1'b1, 32'h000};
        tbl[4]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h008, 1'b1, 32'h000};
        tbl[5]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h008, 1'b1, 32'h000};
        tbl[6]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h00C, 1'b1, 32'h004};
        tbl[7]  = '{1'b0, 1'b1, 32'h102, 1'b0, 32'h010, 1'b1, 32'h008};
        tbl[8]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h000};
        tbl[9]  = '{1'b1, 1'b1, 32'h200, 1'b0, 32'h104, 1'b1, 32'h100};
        tbl[10] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 32'h000};
        tbl[11] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h204, 1'b1, 32'h200};
        tbl[12] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h208, 1'b1, 32'h204};

        rst           = 1'b0;
        rst_w         = 1'b0;
        if_ready      = 1'b1;
        branch_flag   = 1'b0;
        branch_target = 32'h0;
        step();
        step();

        // Streaming from reset with decode always ready: no bubbles.
        rst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) step();
            @(negedge clk);
            chk("strm_ce", {31'h0, rom_ce}, 32'h1);
            chk("strm_addr", rom_addr, 32'(4 * k));
            chk("strm_valid", {31'h0, if_valid}, {31'h0, (k > 0)});
            chk("strm_pc", if_pc, (k > 0) ? 32'(4 * (k - 1)) : 32'h0);
            chk("strm_inst", if_inst, (k > 0) ? rom_word(32'(4 * (k - 1))) : 32'h0);
        end

        // Backpressure, full-buffer branch, branch with simultaneous pop.
        step();
        rst = 1'b0;
        step();
        for (int k = 0; k < 13; k++) begin
            if (k > 0) step();
            rst           = 1'b1;
            if_ready      = tbl[k].ready;
            branch_flag   = tbl[k].br;
            branch_target = tbl[k].tgt;
            @(negedge clk);
            chk($sformatf("tbl%0d_ce", k), {31'h0, rom_ce}, {31'h0, tbl[k].ce});
            chk($sformatf("tbl%0d_addr", k), rom_addr, tbl[k].addr);
            chk($sformatf("tbl%0d_valid", k), {31'h0, if_valid}, {31'h0, tbl[k].valid});
            chk($sformatf("tbl%0d_pc", k), if_pc, tbl[k].pc);
            chk($sformatf("tbl%0d_inst", k), if_inst, tbl[k].valid ? rom_word(tbl[k].pc) : 32'h0);
        end

        // Fill the buffer, then drop reset between edges.
        step();
        branch_flag = 1'b0;
        if_ready    = 1'b0;
        step();
        step();
        #2;
        chk("pre_rst_valid", {31'h0, if_valid}, 32'h1);
        rst = 1'b0;
        #1;
        chk("async_valid", {31'h0, if_valid}, 32'h0);
        chk("async_ce", {31'h0, rom_ce}, 32'h0);
        chk("async_addr", rom_addr, 32'h0);
        step();
        rst      = 1'b1;
        if_ready = 1'b1;
        @(negedge clk);
        chk("rel_addr", rom_addr, 32'h0);
        step();
        @(negedge clk);
        chk("rel_valid", {31'h0, if_valid}, 32'h1);
        chk("rel_pc", if_pc, 32'h0);

        // Random traffic checked by the model.
        for (int k = 0; k < 300; k++) begin
            step();
            if_ready      = ($urandom_range(0, 3) != 0);
            branch_flag   = ($urandom_range(0, 15) == 0);
            branch_target = $urandom;
        end
        step();
        branch_flag = 1'b0;

        // PC wrap through the top of the address space.
        rst_w = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) step();
            @(negedge clk);
            chk("wrap_ce", {31'h0, rom_ce_w}, 32'h1);
            chk("wrap_addr", rom_addr_w, 32'hFFFF_FFF8 + 32'(4 * k));
            if (k > 0) begin
                chk("wrap_pc", if_pc_w, 32'hFFFF_FFF8 + 32'(4 * (k - 1)));
                chk("wrap_inst", if_inst_w, rom_word(32'hFFFF_FFF8 + 32'(4 * (k - 1))));
            end
        end

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
